// File: rtl/mem_access_unit_pkg.sv
// Shared constants, request payload and legality check for the load/store front-end.
package mem_access_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_READ  = 2'b01;
    localparam logic [1:0] S_WRITE = 2'b10;
    localparam logic [1:0] S_RESP  = 2'b11;

    typedef struct packed {
        logic              we;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [ADDR_W-1:0] pc;
    } mem_req_t;

    // Illegal funct3 for the direction, or an address not aligned to the access size.
    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = lo[0];
            F3_W:    err = (lo != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane handling: store merge into a DMem word and load extraction with extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [2:0]        funct3,
    input  logic [1:0]        lane,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] extracted
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [WORD_W-1:0] byte_word;
    logic [WORD_W-1:0] half_word;
    logic [7:0]        b;
    logic [15:0]       h;

    assign byte_sh   = {lane, 3'b000};
    assign half_sh   = {lane[1], 4'b0000};
    assign byte_word = word >> byte_sh;
    assign half_word = word >> half_sh;
    assign b         = byte_word[7:0];
    assign h         = half_word[15:0];

    always_comb begin
        merged = word;
        case (funct3)
            F3_B:    merged[byte_sh +: 8]  = wdata[7:0];
            F3_H:    merged[half_sh +: 16] = wdata[15:0];
            F3_W:    merged = wdata;
            default: merged = word;
        endcase
    end

    always_comb begin
        extracted = '0;
        case (funct3)
            F3_B:    extracted = {{24{b[7]}}, b};
            F3_BU:   extracted = {24'h0, b};
            F3_H:    extracted = {{16{h[15]}}, h};
            F3_HU:   extracted = {16'h0, h};
            F3_W:    extracted = word;
            default: extracted = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store front-end: single outstanding access, sub-word stores via read-modify-write.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_W,
    parameter int unsigned WORD_LEN  = WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_LEN-1:0]  req_wdata,
    input  logic [ADDR_SIZE-1:0] req_pc,
    output logic                 resp_valid,
    output logic [WORD_LEN-1:0]  resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic                 dmem_we,
    output logic [WORD_LEN-1:0]  dmem_wdata,
    output logic [ADDR_SIZE-1:0] dmem_pc,
    input  logic [WORD_LEN-1:0]  dmem_rdata
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    mem_req_t          req_q;
    logic              err_q;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] extracted;

    mem_lane_align u_lane (
        .word      (word_q),
        .wdata     (req_q.wdata),
        .funct3    (req_q.funct3),
        .lane      (req_q.addr[1:0]),
        .merged    (merged),
        .extracted (extracted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture in IDLE; DMem word snapshot in READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            err_q  <= 1'b0;
            word_q <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                req_q.we     <= req_we;
                req_q.funct3 <= req_funct3;
                req_q.addr   <= ADDR_W'(req_addr);
                req_q.wdata  <= WORD_W'(req_wdata);
                req_q.pc     <= ADDR_W'(req_pc);
                err_q        <= access_err(req_we, req_funct3, req_addr[1:0]);
            end
            if (state_q == S_READ) begin
                word_q <= WORD_W'(dmem_rdata);
            end
        end
    end

    // Handshake/strobe outputs decode from state alone so reset kills a pending write at once.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        dmem_we    = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (access_err(req_we, req_funct3, req_addr[1:0])) begin
                        state_d = S_RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = req_q.we ? S_WRITE : S_RESP;
            S_WRITE: begin
                dmem_we = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !req_q.we) begin
                    resp_rdata = WORD_LEN'(extracted);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dmem_addr  = ADDR_SIZE'(req_q.addr);
    assign dmem_pc    = ADDR_SIZE'(req_q.pc);
    assign dmem_wdata = WORD_LEN'(merged);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a byte-addressed memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_pc;
    logic [31:0] dmem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dmem [1024];
    logic [7:0]  ref_bytes [4096];

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_pc    (dmem_pc),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide DMem: combinational read, write on the rising edge.
    assign dmem_rdata = dmem[dmem_addr[11:2]];
    always @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr[11:2]] <= dmem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int acc_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        return (a % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        int base;
        n = acc_bytes(f3);
        base = int'(a[11:0]);
        v = 0;
        for (int k = 0; k < n; k++) v |= 32'(ref_bytes[base + k]) << (8 * k);
        if (n < 4 && !f3[2] && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'({a[11:2], 2'b00});
        return {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
    endfunction

    // Issue one access from IDLE (called at a falling edge); returns at the falling edge back in IDLE.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd_o,
                             output logic [31:0] wr_o, output int lat_o);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          we_cnt;
        logic        got;
        logic [31:0] pc;
        e_err = model_err(we, f3, a);
        e_rd  = (we || e_err) ? 32'h0 : model_load(f3, a);
        e_lat = e_err ? 1 : (!we ? 2 : (f3 == 3'b010 ? 2 : 3));
        pc    = $urandom;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_pc = pc;
        check("ready_at_issue", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom; req_addr = $urandom;
        lat_o = 0; we_cnt = 0; got = 1'b0; wr_o = 32'h0; rd_o = 32'h0;
        while (!got && lat_o < 10) begin
            @(negedge clk);
            lat_o++;
            if (dmem_we) begin
                we_cnt++;
                wr_o = dmem_wdata;
                check("wr_addr", dmem_addr, a);
                check("wr_pc", dmem_pc, pc);
            end
            if (resp_valid) begin
                got  = 1'b1;
                rd_o = resp_rdata;
            end
        end
        if (we && !e_err) begin
            for (int k = 0; k < acc_bytes(f3); k++)
                ref_bytes[int'(a[11:0]) + k] = 8'(wd >> (8 * k));
            check("wr_word", wr_o, model_word(a));
        end
        check("latency", 32'(lat_o), 32'(e_lat));
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_rdata", rd_o, e_rd);
        check("we_pulses", 32'(we_cnt), (we && !e_err) ? 32'd1 : 32'd0);
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic [31:0] wr;
    int          lat;
    int          n;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = $urandom;
            dmem[i] = w;
            for (int k = 0; k < 4; k++) ref_bytes[4 * i + k] = 8'(w >> (8 * k));
        end
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_dmem_wdata", dmem_wdata, 32'h0);
        check("rst_dmem_pc", dmem_pc, 32'h0);

        // Release reset together with the first request.
        rst_n = 1'b1;
        do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, wr, lat);
        check("sw_word", wr, 32'hDEADBEEF);
        check("sw_lat", 32'(lat), 32'd2);
        do_access(1'b1, 3'b000, 32'h11, 32'h000000AA, rd, wr, lat);
        check("sb_word", wr, 32'hDEADAAEF);
        check("sb_lat", 32'(lat), 32'd3);
        do_access(1'b0, 3'b100, 32'h11, 32'h0, rd, wr, lat);
        check("lbu", rd, 32'h000000AA);
        do_access(1'b0, 3'b000, 32'h11, 32'h0, rd, wr, lat);
        check("lb", rd, 32'hFFFFFFAA);
        do_access(1'b1, 3'b001, 32'h12, 32'h00001234, rd, wr, lat);
        check("sh_word", wr, 32'h1234AAEF);
        do_access(1'b0, 3'b001, 32'h12, 32'h0, rd, wr, lat);
        check("lh_hi", rd, 32'h00001234);
        do_access(1'b0, 3'b001, 32'h10, 32'h0, rd, wr, lat);
        check("lh_lo", rd, 32'hFFFFAAEF);
        do_access(1'b0, 3'b101, 32'h10, 32'h0, rd, wr, lat);
        check("lhu_lo", rd, 32'h0000AAEF);
        do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, wr, lat);
        check("lw", rd, 32'h1234AAEF);
        check("lw_lat", 32'(lat), 32'd2);
        do_access(1'b0, 3'b010, 32'h13, 32'h0, rd, wr, lat);
        check("lw_mis_lat", 32'(lat), 32'd1);
        do_access(1'b1, 3'b001, 32'h11, 32'hFFFF, rd, wr, lat);
        check("sh_mis_lat", 32'(lat), 32'd1);
        do_access(1'b0, 3'b011, 32'h20, 32'h0, rd, wr, lat);
        check("ld_f3_011_lat", 32'(lat), 32'd1);

        // Reset during the WRITE cycle of an SB must suppress the write.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10;
        req_wdata = 32'h55; req_pc = 32'h400;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (dmem_we !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_saw_write", 32'(dmem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we_drop", 32'(dmem_we), 32'd0);
        check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, wr, lat);
        check("rst_mid_word_kept", rd, 32'h1234AAEF);

        // Randomized mix, including upper address bits that alias onto the same DMem words.
        for (int i = 0; i < 300; i++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] ra;
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            do_access(rwe, rf3, ra, $urandom, rd, wr, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
